uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive buffer directly downstream of the UART receiver. Captures each byte
//  presented on d_rx when rx_done rises and queues it in a DEPTH-entry circular
//  FIFO. Exposes a show-ahead read port, status flags, a sticky overrun flag and
//  a level interrupt to the core's memory-mapped UART register block.
// PARAMETERS
//  DW      8   data width of each entry (matches receiver byte width)
//  DEPTH   16  number of entries; power of two, >= 2
//  THRESH  1   irq asserts when count >= THRESH; range 1..DEPTH
//  AW      $clog2(DEPTH)  derived pointer width; never overridden
// PORTS
//  clk      in   1     system clock; all state changes on posedge
//  reset    in   1     asynchronous, active-low reset (0 = in reset)
//  d_rx     in   DW    received byte from receiver; valid when rx_done is high
//  rx_done  in   1     receiver done level; may stay high for several cycles
//  rd_en    in   1     pop request from register block; one entry per cycle
//  flush    in   1     synchronous clear of FIFO contents
//  ovr_clr  in   1     synchronous clear of overrun flag
//  rd_data  out  DW    head entry, show-ahead; valid only while empty == 0
//  empty    out  1     count == 0
//  full     out  1     count == DEPTH
//  count    out  AW+1  entries held, 0..DEPTH
//  overrun  out  1     sticky: a byte was dropped because FIFO was full
//  irq      out  1     registered: (count >= THRESH) | overrun
// BEHAVIOUR
//  Reset (reset == 0, async):
//  - wr_ptr, rd_ptr, count, overrun and irq go to 0; empty = 1, full = 0.
//  - rx_done_q goes to 1 so a rx_done still high after reset is not a write.
//  - Storage array is not reset; rd_data is don't-care while empty.
//  Write detect:
//  - rx_done_q <= rx_done every cycle.
//  - wr_req = rx_done & ~rx_done_q, i.e. one request per rising edge.
//  - d_rx is sampled in the wr_req cycle.
//  Write:
//  - If wr_req & ~full: mem[wr_ptr] <= d_rx and wr_ptr <= wr_ptr + 1 (mod DEPTH).
//  - If wr_req & full & ~rd_en: the byte is dropped and overrun <= 1.
//  - If wr_req & full & rd_en: the pop frees a slot, so the write is accepted and
//    overrun does not change.
//  Read:
//  - If rd_en & ~empty: rd_ptr <= rd_ptr + 1 (mod DEPTH).
//  - rd_data = mem[rd_ptr] combinationally, so there is zero latency to the head.
//  - If rd_en & empty: ignored; no underflow and no pointer movement.
//  Count:
//  - count +1 on an accepted write only, -1 on an accepted read only.
//  - Unchanged when both are accepted in the same cycle.
//  - Pointer wrap at DEPTH-1 -> 0; count never exceeds DEPTH.
//  Write-to-read latency:
//  - A byte written at edge N is visible on rd_data, with empty = 0, after edge N.
//  - If a pop is requested while empty at the same cycle as a write, the pop is
//    ignored and the byte remains.
//  Flush:
//  - Pointers and count go to 0 and any same-cycle rd_en is ignored.
//  - A same-cycle wr_req is also discarded.
//  - Overrun is unaffected by flush.
//  Overrun clear:
//  - ovr_clr sets overrun to 0.
//  - If a new overrun occurs in the same cycle, set wins and overrun = 1.
//  irq:
//  - Registered one cycle after the count or overrun change that causes it.
//  - Falls only when both conditions are cleared.
//  No FSM beyond the edge detector; all outputs except rd_data are registered or
//  decoded from registers.
// TESTING
//  1. Reset while rx_done = 1: release reset with rx_done held -> no write; count
//     stays 0, empty stays 1.
//  2. Write 0xA5: pulse rx_done high for 3 cycles -> exactly one write; count = 1,
//     rd_data = 0xA5. rd_en for 1 cycle -> empty = 1.
//  3. Fill to DEPTH: write 0x00..0x0F -> full = 1, count = 16. Write 0x55 ->
//     dropped, overrun = 1, irq = 1. Pops return 0x00..0x0F in order.
//  4. With the FIFO full, assert rx_done edge (0x77) and rd_en in the same cycle
//     -> count stays 16, overrun stays 0, 0x77 is last out.
//  5. Wrap: 40 writes interleaved with pops, keeping count at 1..3 -> in-order
//     data, and pointers wrap cleanly.
//  6. In the same cycle: ovr_clr with an overrun -> overrun = 1. Then flush at
//     count = 5 -> count = 0 and overrun is still 1. Then ovr_clr alone ->
//     overrun = 0, and irq = 0 on the next cycle.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive buffer sitting directly behind the UART receiver. Every rising edge
// of rx_done captures the byte on d_rx into a DEPTH-entry circular FIFO. The
// register block reads it through a show-ahead port: the head entry is always
// on rd_data and a pop simply advances past it.
//
// Ports
//   clk      in            system clock, all state changes on posedge
//   reset    in            asynchronous reset, active low (0 = in reset)
//   d_rx     in  [DW-1:0]  received byte, valid while rx_done is high
//   rx_done  in            receiver done level, may stay high several cycles
//   rd_en    in            pop request, one entry per cycle
//   flush    in            synchronous clear of FIFO contents
//   ovr_clr  in            synchronous clear of the overrun flag
//   rd_data  out [DW-1:0]  head entry, valid only while empty == 0
//   empty    out           count == 0
//   full     out           count == DEPTH
//   count    out [AW:0]    entries held, 0..DEPTH
//   overrun  out           sticky: a byte was dropped because FIFO was full
//   irq      out           registered (count >= THRESH) | overrun
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter  int DW     = 8,
  parameter  int DEPTH  = 16,
  parameter  int THRESH = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] d_rx,
  input  logic          rx_done,
  input  logic          rd_en,
  input  logic          flush,
  input  logic          ovr_clr,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          irq
);

  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH_C = (AW+1)'(THRESH);

  // Storage and state
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overrun;
  logic          r_irq;
  logic          r_rx_done_q;

  // Decoded control
  logic w_empty;
  logic w_full;
  logic w_wr_req;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_drop;

  // NOTE: control decode is done with continuous assigns so every signal is
  // fully specified on every path and no latch can be inferred.
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == DEPTH_C);

  // One write request per rising edge of the receiver's done level.
  assign w_wr_req = rx_done & ~r_rx_done_q;

  // Flush overrides both ports for the cycle it is asserted.
  assign w_rd_acc = rd_en & ~w_empty & ~flush;

  // When full, a same-cycle pop frees the slot being written, so the write is
  // still accepted (wr_ptr == rd_ptr in that case).
  assign w_wr_acc = w_wr_req & ~flush & (~w_full | w_rd_acc);

  // A byte is lost only when it arrives full with nothing leaving.
  assign w_drop   = w_wr_req & ~flush & w_full & ~rd_en;

  // Control state
  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers sample pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // Start the edge detector high so a done level still asserted as reset
      // releases is not mistaken for a fresh byte.
      r_rx_done_q <= 1'b1;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overrun   <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_rx_done_q <= rx_done;

      // irq tracks the registered status with one cycle of delay.
      r_irq <= (r_count >= THRESH_C) | r_overrun;

      // A new overrun beats a same-cycle clear.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end

      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        // DEPTH is a power of two, so pointers wrap by natural overflow.
        if (w_wr_acc) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_rd_acc) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        if (w_wr_acc && !w_rd_acc) begin
          r_count <= r_count + 1'b1;
        end else if (w_rd_acc && !w_wr_acc) begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through entries that were written after reset, so clearing it buys
  // nothing and keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= d_rx;
    end
  end

  // Outputs
  assign rd_data = r_mem[r_rd_ptr];
  assign empty   = w_empty;
  assign full    = w_full;
  assign count   = r_count;
  assign overrun = r_overrun;
  assign irq     = r_irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Drives directed scenarios followed by randomized traffic into uart_rx_fifo.
// A queue-based reference model tracks the expected contents, overrun and irq;
// a compare process checks every output against it on each falling edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int THRESH = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] d_rx;
  logic          rx_done;
  logic          rd_en;
  logic          flush;
  logic          ovr_clr;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [4:0]    count;
  logic          overrun;
  logic          irq;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DW     (DW),
    .DEPTH  (DEPTH),
    .THRESH (THRESH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .d_rx    (d_rx),
    .rx_done (rx_done),
    .rd_en   (rd_en),
    .flush   (flush),
    .ovr_clr (ovr_clr),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overrun (overrun),
    .irq     (irq)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  bit            m_ovr;
  bit            m_irq;
  bit            m_rxq;
  bit            chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr = 1'b0;
    m_irq = 1'b0;
    m_rxq = 1'b1;
  endtask

  // Applies one clock edge worth of behaviour using the inputs held across it.
  task automatic model_step();
    bit wr_req;
    bit irq_nx;
    bit drop;
    bit rd_ok;
    bit was_full;
    wr_req = rx_done && !m_rxq;
    irq_nx = (mq.size() >= THRESH) || m_ovr;
    drop   = 1'b0;
    m_rxq  = rx_done;
    if (flush) begin
      mq.delete();
    end else begin
      was_full = (mq.size() == DEPTH);
      rd_ok    = rd_en && (mq.size() > 0);
      if (rd_ok) void'(mq.pop_front());
      if (wr_req) begin
        if (!was_full || rd_ok) mq.push_back(d_rx);
        else drop = 1'b1;
      end
    end
    if (drop) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
    m_irq = irq_nx;
  endtask

  // Compare process: every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("empty",   32'(empty),   32'(mq.size() == 0));
      check("full",    32'(full),    32'(mq.size() == DEPTH));
      check("count",   32'(count),   32'(mq.size()));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("irq",     32'(irq),     32'(m_irq));
      if (mq.size() != 0) check("rd_data", 32'(rd_data), 32'(mq[0]));
    end
  end

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic rx, input logic [DW-1:0] d, input logic rd,
                      input logic fl, input logic oc);
    rx_done = rx;
    d_rx    = d;
    rd_en   = rd;
    flush   = fl;
    ovr_clr = oc;
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [DW-1:0] d, input logic rd);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, d, rd, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] exp_b;
    bit            rx_lvl;
    int            rd_pct;

    reset   = 1'b0;
    rx_done = 1'b1;
    d_rx    = '0;
    rd_en   = 1'b0;
    flush   = 1'b0;
    ovr_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_count",   32'(count),   32'd0);
    check("rst_empty",   32'(empty),   32'd1);
    check("rst_full",    32'(full),    32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_irq",     32'(irq),     32'd0);
    chk_en = 1'b1;

    // 1. Release reset with rx_done held high: no write.
    reset = 1'b1;
    repeat (3) step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    check("t1_count", 32'(count), 32'd0);
    check("t1_empty", 32'(empty), 32'd1);

    // 2. rx_done high for three cycles -> exactly one write.
    idle();
    repeat (3) step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    check("t2_count", 32'(count),   32'd1);
    check("t2_data",  32'(rd_data), 32'hA5);
    pop();
    check("t2_empty", 32'(empty), 32'd1);

    // 3. Fill, overflow, drain in order.
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0);
    check("t3_full",  32'(full),  32'd1);
    check("t3_count", 32'(count), 32'd16);
    push(8'h55, 1'b0);
    check("t3_overrun", 32'(overrun), 32'd1);
    check("t3_irq",     32'(irq),     32'd1);
    check("t3_count2",  32'(count),   32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      check("t3_pop", 32'(rd_data), 32'(i));
      pop();
    end
    check("t3_empty", 32'(empty), 32'd1);

    // 4. Full with same-cycle write and pop.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t4_ovr_clr", 32'(overrun), 32'd0);
    for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i), 1'b0);
    push(8'h77, 1'b1);
    check("t4_count",   32'(count),   32'd16);
    check("t4_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      exp_b = (i == DEPTH - 1) ? 8'h77 : 8'(8'h11 + i);
      check("t4_pop", 32'(rd_data), 32'(exp_b));
      pop();
    end

    // 5. Wrap: 40 writes each paired with a pop, count held at 2.
    push(8'hC0, 1'b0);
    push(8'hC1, 1'b0);
    for (int i = 0; i < 40; i++) push(8'(8'h40 + i), 1'b1);
    check("t5_count", 32'(count),   32'd2);
    check("t5_head",  32'(rd_data), 32'h66);
    pop();
    pop();

    // 6. Overrun set beats clear; flush keeps overrun; clear then irq falls.
    for (int i = 0; i < DEPTH; i++) push(8'(8'h20 + i), 1'b0);
    idle();
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    check("t6_set_wins", 32'(overrun), 32'd1);
    for (int i = 0; i < 11; i++) pop();
    check("t6_count5", 32'(count), 32'd5);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    check("t6_flush_count", 32'(count),   32'd0);
    check("t6_flush_ovr",   32'(overrun), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t6_clr_ovr", 32'(overrun), 32'd0);
    idle();
    check("t6_irq_low", 32'(irq), 32'd0);

    // Randomized traffic: alternating write-heavy and read-heavy phases.
    rx_lvl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rd_pct = ((c / 300) % 2 == 0) ? 15 : 70;
      rx_lvl = ($urandom_range(0, 99) < 55) ? ~rx_lvl : rx_lvl;
      step(rx_lvl, 8'($urandom),
           $urandom_range(0, 99) < rd_pct,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 4);
    end

    // Asynchronous reset mid-traffic with rx_done held high.
    #2;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst2_count", 32'(count), 32'd0);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    check("rst2_nowrite", 32'(empty), 32'd1);

    for (int c = 0; c < 500; c++) begin
      rx_lvl = ($urandom_range(0, 99) < 50) ? ~rx_lvl : rx_lvl;
      step(rx_lvl, 8'($urandom), $urandom_range(0, 99) < 40, 1'b0,
           $urandom_range(0, 99) < 5);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
